// File: rtl/fofb_links_pkg.sv
// Shared constants and helpers for the FOFB link mux/demux blocks.
package fofb_links_pkg;

  localparam int FOFB_DATA_WIDTH  = 8;
  localparam int FOFB_USER_WIDTH  = 1;
  localparam int FOFB_NUM_LINKS   = 2;
  localparam int FOFB_FIFO_DEPTH  = 8;
  localparam int DROP_COUNT_WIDTH = 16;

  typedef logic [DROP_COUNT_WIDTH-1:0] drop_count_t;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic drop_count_t sat_inc(input drop_count_t value);
    drop_count_t result;
    result = (value == '1) ? value : drop_count_t'(value + 1'b1);
    return result;
  endfunction

endpackage

// File: rtl/fofb_write_links_demux_if.sv
// Bundle of the stream, link and status signals around the write-links demux.
// The "slave" modport is the demux's view: it receives the cell-controller
// stream and drives the link streams. The "master" modport is the environment.
interface fofb_write_links_demux_if
  import fofb_links_pkg::*;
#(
  parameter int NUM_DESTS  = FOFB_NUM_LINKS,
  parameter int DATA_WIDTH = FOFB_DATA_WIDTH,
  parameter int USER_WIDTH = FOFB_USER_WIDTH
) ();

  logic                            S_AXIS_TVALID;
  logic                            S_AXIS_TREADY;
  logic [DATA_WIDTH-1:0]           S_AXIS_TDATA;
  logic [USER_WIDTH-1:0]           S_AXIS_TUSER;
  logic [NUM_DESTS-1:0]            S_AXIS_TDEST;
  logic [NUM_DESTS-1:0]            M_AXIS_TVALID;
  logic [NUM_DESTS-1:0]            M_AXIS_TREADY;
  logic [NUM_DESTS*DATA_WIDTH-1:0] M_AXIS_TDATA;
  logic [NUM_DESTS*USER_WIDTH-1:0] M_AXIS_TUSER;
  logic [NUM_DESTS-1:0]            LINK_ENABLE;
  logic [DROP_COUNT_WIDTH-1:0]     DROP_COUNT;

  modport slave (
    input  S_AXIS_TVALID, S_AXIS_TDATA, S_AXIS_TUSER, S_AXIS_TDEST,
    input  M_AXIS_TREADY, LINK_ENABLE,
    output S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TUSER, DROP_COUNT
  );

  modport master (
    output S_AXIS_TVALID, S_AXIS_TDATA, S_AXIS_TUSER, S_AXIS_TDEST,
    output M_AXIS_TREADY, LINK_ENABLE,
    input  S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TUSER, DROP_COUNT
  );

endinterface

// File: rtl/fofb_link_fifo.sv
// Single-clock first-word-fall-through FIFO for one outgoing link.
// Pointers carry one extra wrap bit so full and empty are distinguishable;
// both flags decode registered pointers only, keeping upstream ready short.
module fofb_link_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty;

  // Head entry is presented directly from storage, so data is valid with !empty.
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Storage write; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // Pointer update; a flush empties the FIFO in one edge and wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fofb_write_links_demux.sv
// FOFB write-links demux: fans single-beat packets from the cell controller out
// to every enabled link selected by TDEST, buffering each link in its own FIFO.
// Beats whose destinations are all disabled are counted and dropped.
module fofb_write_links_demux
  import fofb_links_pkg::*;
#(
  parameter int NUM_DESTS  = FOFB_NUM_LINKS,
  parameter int DATA_WIDTH = FOFB_DATA_WIDTH,
  parameter int USER_WIDTH = FOFB_USER_WIDTH,
  parameter int FIFO_DEPTH = FOFB_FIFO_DEPTH
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  fofb_write_links_demux_if.slave  axis
);

  localparam int ENTRY_WIDTH = DATA_WIDTH + USER_WIDTH;

  logic [1:0]             rst_sync;
  logic                   rst_n_int;
  logic [NUM_DESTS-1:0]   eff_mask;
  logic [NUM_DESTS-1:0]   full_vec;
  logic [NUM_DESTS-1:0]   empty_vec;
  logic [NUM_DESTS-1:0]   push_vec;
  logic [NUM_DESTS-1:0]   blocked;
  logic                   ready;
  logic                   accept;
  logic [ENTRY_WIDTH-1:0] wr_entry;
  logic [ENTRY_WIDTH-1:0] rd_entry [NUM_DESTS];
  drop_count_t            drop_count;

  // Reset synchroniser: assert asynchronously, release two edges after ARESETN rises.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rst_sync <= '0;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n_int = rst_sync[1];

  // A beat is only held back by a full FIFO on a link it actually targets, so
  // ready never looks at the downstream link readies. Raw ARESETN drops ready
  // at once; the synchronised reset keeps it low until the FIFOs are released.
  assign eff_mask = axis.S_AXIS_TDEST & axis.LINK_ENABLE;
  assign blocked  = eff_mask & full_vec;
  assign ready    = ARESETN & rst_n_int & ~(|blocked);
  assign accept   = axis.S_AXIS_TVALID & ready;
  assign push_vec = {NUM_DESTS{accept}} & eff_mask;
  assign wr_entry = {axis.S_AXIS_TUSER, axis.S_AXIS_TDATA};

  assign axis.S_AXIS_TREADY = ready;
  assign axis.M_AXIS_TVALID = ~empty_vec;
  assign axis.DROP_COUNT    = drop_count;

  // One FIFO per link; a disabled link is held flushed so it stays empty.
  for (genvar i = 0; i < NUM_DESTS; i++) begin : g_link
    fofb_link_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_WIDTH)
    ) u_fifo (
      .clk     (ACLK),
      .rst_n   (rst_n_int),
      .push    (push_vec[i]),
      .pop     (axis.M_AXIS_TREADY[i]),
      .flush   (~axis.LINK_ENABLE[i]),
      .wr_data (wr_entry),
      .rd_data (rd_entry[i]),
      .full    (full_vec[i]),
      .empty   (empty_vec[i])
    );
  end

  // Unpack each FIFO head into the flat per-link data and user buses.
  always_comb begin
    axis.M_AXIS_TDATA = '0;
    axis.M_AXIS_TUSER = '0;
    for (int i = 0; i < NUM_DESTS; i++) begin
      axis.M_AXIS_TDATA[i*DATA_WIDTH +: DATA_WIDTH] = rd_entry[i][DATA_WIDTH-1:0];
      axis.M_AXIS_TUSER[i*USER_WIDTH +: USER_WIDTH] = rd_entry[i][ENTRY_WIDTH-1:DATA_WIDTH];
    end
  end

  // Count accepted beats that had nowhere to go, saturating at all-ones.
  always_ff @(posedge ACLK or negedge rst_n_int) begin
    if (!rst_n_int) begin
      drop_count <= '0;
    end else if (accept && (eff_mask == '0)) begin
      drop_count <= sat_inc(drop_count);
    end
  end

endmodule

// File: tb/tb_fofb_write_links_demux.sv
// Self-checking bench for the FOFB write-links demux: directed table, hand
// sequences for back-pressure, link flush and reset, then random traffic
// compared against a queue-based reference model.
module tb_fofb_write_links_demux;

  logic ACLK;
  logic ARESETN;

  int checks   = 0;
  int failures = 0;

  // Reference model state: one queue of {user,data} per link.
  logic [8:0]  q0 [$];
  logic [8:0]  q1 [$];
  logic [15:0] exp_drop;
  int          sync_edges;

  typedef struct {
    logic        tv;
    logic [1:0]  dest;
    logic [7:0]  data;
    logic [1:0]  mrdy;
    logic [1:0]  en;
    logic        exp_rdy;
    logic [1:0]  exp_mv;
    logic [7:0]  exp_d0;
    logic [7:0]  exp_d1;
    logic [15:0] exp_drop;
  } vec_t;

  vec_t tbl [11];

  fofb_write_links_demux_if #(.NUM_DESTS(2), .DATA_WIDTH(8), .USER_WIDTH(1)) bus ();

  fofb_write_links_demux #(
    .NUM_DESTS  (2),
    .DATA_WIDTH (8),
    .USER_WIDTH (1),
    .FIFO_DEPTH (8)
  ) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .axis    (bus)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  function automatic int qsize(int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [8:0] qfront(int i);
    return (i == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpush(int i, logic [8:0] v);
    if (i == 0) q0.push_back(v);
    else q1.push_back(v);
  endtask

  task automatic qpop(int i);
    if (i == 0) void'(q0.pop_front());
    else void'(q1.pop_front());
  endtask

  task automatic qclear(int i);
    if (i == 0) q0.delete();
    else q1.delete();
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    exp_drop   = 16'd0;
    sync_edges = 0;
  endtask

  // Upstream may send whenever every enabled target link still has room.
  function automatic logic model_ready();
    if (!ARESETN || sync_edges < 2) return 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (bus.S_AXIS_TDEST[i] && bus.LINK_ENABLE[i] && qsize(i) >= 8) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(logic tv, logic [1:0] dest, logic [7:0] data,
                                logic user, logic [1:0] mrdy, logic [1:0] en);
    bus.S_AXIS_TVALID = tv;
    bus.S_AXIS_TDEST  = dest;
    bus.S_AXIS_TDATA  = data;
    bus.S_AXIS_TUSER  = user;
    bus.M_AXIS_TREADY = mrdy;
    bus.LINK_ENABLE   = en;
  endtask

  task automatic expect_ready(string name, logic exp);
    #1;
    check_output(name, bus.S_AXIS_TREADY, exp);
  endtask

  // Compare all outputs against the model, then advance one clock and update it.
  task automatic step();
    logic       exp_rdy;
    logic       acc;
    logic [1:0] eff;
    logic [1:0] pops;
    logic [1:0] en;
    logic [8:0] entry;
    logic       expv;
    #1;
    exp_rdy = model_ready();
    check_output("s_tready", bus.S_AXIS_TREADY, exp_rdy);
    pops = 2'b00;
    for (int i = 0; i < 2; i++) begin
      expv = (qsize(i) > 0);
      check_output($sformatf("m_tvalid%0d", i), bus.M_AXIS_TVALID[i], expv);
      if (expv) begin
        check_output($sformatf("m_entry%0d", i),
                     {bus.M_AXIS_TUSER[i], bus.M_AXIS_TDATA[i*8 +: 8]}, qfront(i));
      end
      pops[i] = expv & bus.M_AXIS_TREADY[i];
    end
    check_output("drop_count", bus.DROP_COUNT, exp_drop);
    en    = bus.LINK_ENABLE;
    eff   = bus.S_AXIS_TDEST & en;
    acc   = bus.S_AXIS_TVALID & exp_rdy;
    entry = {bus.S_AXIS_TUSER, bus.S_AXIS_TDATA};
    @(posedge ACLK);
    if (ARESETN) begin
      if (sync_edges >= 2) begin
        for (int i = 0; i < 2; i++) begin
          if (!en[i]) begin
            qclear(i);
          end else begin
            if (pops[i]) qpop(i);
            if (acc && eff[i]) qpush(i, entry);
          end
        end
        if (acc && eff == 2'b00 && exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
      end else begin
        sync_edges++;
      end
    end
    #1;
  endtask

  initial begin
    model_reset();
    ARESETN = 1'b0;
    apply_stimulus(1'b0, 2'b00, 8'h00, 1'b0, 2'b11, 2'b11);

    // Reset state and release through the synchroniser.
    repeat (3) @(posedge ACLK);
    #1;
    check_output("rst_mvalid", bus.M_AXIS_TVALID, 2'b00);
    check_output("rst_tready", bus.S_AXIS_TREADY, 1'b0);
    check_output("rst_drop", bus.DROP_COUNT, 16'd0);
    ARESETN = 1'b1;
    step();
    step();

    // Directed table: single-link beat, broadcast stream, drop, disabled link.
    tbl[0]  = '{1'b1, 2'b01, 8'hA5, 2'b11, 2'b11, 1'b1, 2'b00, 8'h00, 8'h00, 16'd0};
    tbl[1]  = '{1'b0, 2'b00, 8'h00, 2'b11, 2'b11, 1'b1, 2'b01, 8'hA5, 8'h00, 16'd0};
    tbl[2]  = '{1'b1, 2'b11, 8'h11, 2'b11, 2'b11, 1'b1, 2'b00, 8'h00, 8'h00, 16'd0};
    tbl[3]  = '{1'b1, 2'b11, 8'h12, 2'b11, 2'b11, 1'b1, 2'b11, 8'h11, 8'h11, 16'd0};
    tbl[4]  = '{1'b1, 2'b11, 8'h13, 2'b11, 2'b11, 1'b1, 2'b11, 8'h12, 8'h12, 16'd0};
    tbl[5]  = '{1'b0, 2'b00, 8'h00, 2'b11, 2'b11, 1'b1, 2'b11, 8'h13, 8'h13, 16'd0};
    tbl[6]  = '{1'b0, 2'b00, 8'h00, 2'b11, 2'b11, 1'b1, 2'b00, 8'h00, 8'h00, 16'd0};
    tbl[7]  = '{1'b1, 2'b10, 8'h77, 2'b11, 2'b01, 1'b1, 2'b00, 8'h00, 8'h00, 16'd0};
    tbl[8]  = '{1'b1, 2'b11, 8'h88, 2'b11, 2'b01, 1'b1, 2'b00, 8'h00, 8'h00, 16'd1};
    tbl[9]  = '{1'b0, 2'b00, 8'h00, 2'b11, 2'b01, 1'b1, 2'b01, 8'h88, 8'h00, 16'd1};
    tbl[10] = '{1'b0, 2'b00, 8'h00, 2'b11, 2'b11, 1'b1, 2'b00, 8'h00, 8'h00, 16'd1};
    for (int r = 0; r < 11; r++) begin
      apply_stimulus(tbl[r].tv, tbl[r].dest, tbl[r].data, 1'b0, tbl[r].mrdy, tbl[r].en);
      #1;
      check_output($sformatf("tbl%0d_ready", r), bus.S_AXIS_TREADY, tbl[r].exp_rdy);
      check_output($sformatf("tbl%0d_mvalid", r), bus.M_AXIS_TVALID, tbl[r].exp_mv);
      check_output($sformatf("tbl%0d_drop", r), bus.DROP_COUNT, tbl[r].exp_drop);
      if (tbl[r].exp_mv[0]) check_output($sformatf("tbl%0d_d0", r), bus.M_AXIS_TDATA[7:0], tbl[r].exp_d0);
      if (tbl[r].exp_mv[1]) check_output($sformatf("tbl%0d_d1", r), bus.M_AXIS_TDATA[15:8], tbl[r].exp_d1);
      step();
    end

    // Back-pressure on link1 fills its FIFO; ready returns one cycle after the first pop.
    for (int k = 0; k < 8; k++) begin
      apply_stimulus(1'b1, 2'b11, 8'h30 + 8'(k), 1'b1, 2'b01, 2'b11);
      expect_ready($sformatf("bp_fill%0d_ready", k), 1'b1);
      step();
    end
    apply_stimulus(1'b1, 2'b11, 8'h38, 1'b1, 2'b01, 2'b11);
    expect_ready("bp_full_ready", 1'b0);
    step();
    check_output("bp_mvalid", bus.M_AXIS_TVALID, 2'b10);
    apply_stimulus(1'b1, 2'b11, 8'h38, 1'b1, 2'b11, 2'b11);
    expect_ready("bp_first_pop_ready", 1'b0);
    step();
    expect_ready("bp_after_pop_ready", 1'b1);
    step();
    apply_stimulus(1'b0, 2'b00, 8'h00, 1'b0, 2'b11, 2'b11);
    repeat (10) step();

    // Link1 holding four beats is flushed when disabled; after re-enable only new data appears.
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1'b1, 2'b10, 8'h60 + 8'(k), 1'b0, 2'b00, 2'b11);
      step();
    end
    apply_stimulus(1'b0, 2'b00, 8'h00, 1'b0, 2'b00, 2'b01);
    #1;
    check_output("flush_before", bus.M_AXIS_TVALID[1], 1'b1);
    step();
    check_output("flush_after", bus.M_AXIS_TVALID, 2'b00);
    step();
    check_output("flush_hold", bus.M_AXIS_TVALID, 2'b00);
    apply_stimulus(1'b0, 2'b00, 8'h00, 1'b0, 2'b00, 2'b11);
    step();
    apply_stimulus(1'b1, 2'b10, 8'h42, 1'b0, 2'b10, 2'b11);
    step();
    apply_stimulus(1'b0, 2'b00, 8'h00, 1'b0, 2'b10, 2'b11);
    check_output("reenable_valid", bus.M_AXIS_TVALID, 2'b10);
    check_output("reenable_data", bus.M_AXIS_TDATA[15:8], 8'h42);
    step();
    check_output("reenable_only_one", bus.M_AXIS_TVALID, 2'b00);

    // Reset asserted mid-burst with both FIFOs partly full.
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(1'b1, 2'b11, 8'h70 + 8'(k), 1'b0, 2'b00, 2'b11);
      step();
    end
    apply_stimulus(1'b1, 2'b11, 8'h73, 1'b0, 2'b00, 2'b11);
    ARESETN = 1'b0;
    model_reset();
    #1;
    check_output("midrst_mvalid", bus.M_AXIS_TVALID, 2'b00);
    check_output("midrst_tready", bus.S_AXIS_TREADY, 1'b0);
    repeat (2) @(posedge ACLK);
    #1;
    check_output("midrst_drop", bus.DROP_COUNT, 16'd0);
    ARESETN = 1'b1;
    apply_stimulus(1'b0, 2'b00, 8'h00, 1'b0, 2'b11, 2'b11);
    step();
    step();
    check_output("postrst_mvalid", bus.M_AXIS_TVALID, 2'b00);
    apply_stimulus(1'b1, 2'b01, 8'h9A, 1'b0, 2'b11, 2'b11);
    expect_ready("postrst_ready", 1'b1);
    step();
    apply_stimulus(1'b0, 2'b00, 8'h00, 1'b0, 2'b11, 2'b11);
    check_output("postrst_mvalid_first", bus.M_AXIS_TVALID, 2'b01);
    check_output("postrst_data_first", bus.M_AXIS_TDATA[7:0], 8'h9A);
    step();

    // Beats aimed only at a disabled link are accepted and counted as drops.
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(1'b1, 2'b10, 8'h80 + 8'(k), 1'b0, 2'b11, 2'b01);
      expect_ready($sformatf("drop%0d_ready", k), 1'b1);
      step();
    end
    check_output("drop_count5", bus.DROP_COUNT, 16'd5);
    check_output("drop_mvalid", bus.M_AXIS_TVALID, 2'b00);
    apply_stimulus(1'b1, 2'b11, 8'h5E, 1'b0, 2'b11, 2'b01);
    step();
    apply_stimulus(1'b0, 2'b00, 8'h00, 1'b0, 2'b11, 2'b01);
    check_output("partial_mvalid", bus.M_AXIS_TVALID, 2'b01);
    check_output("partial_data", bus.M_AXIS_TDATA[7:0], 8'h5E);
    step();

    // Random traffic, back-pressure and occasional link toggles against the model.
    apply_stimulus(1'b0, 2'b00, 8'h00, 1'b0, 2'b11, 2'b11);
    for (int c = 0; c < 800; c++) begin
      logic [1:0] en;
      logic [1:0] mrdy;
      en = bus.LINK_ENABLE;
      if ($urandom_range(0, 39) == 0) en[$urandom_range(0, 1)] = ~en[$urandom_range(0, 1)];
      if ($urandom_range(0, 19) == 0) en = 2'b11;
      mrdy[0] = ($urandom_range(0, 9) < 7);
      mrdy[1] = ($urandom_range(0, 9) < 6);
      apply_stimulus($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                     8'($urandom), 1'($urandom), mrdy, en);
      step();
    end
    apply_stimulus(1'b0, 2'b00, 8'h00, 1'b0, 2'b11, 2'b11);
    repeat (12) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
